// File: rtl/loc_bus_target.sv
// Local-bus target: grants the bus, latches the address phase on ADSn, waits a programmable
// number of cycles, then completes the data phase against a 16 x 32-bit register file.
module loc_bus_target #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFC0
) (
    input  logic        CLOCK,
    input  logic        RESETn,
    input  logic        LHOLD,
    output logic        LHOLDA,
    input  logic        LOCAL_BUSY,
    input  logic        ADSn,
    input  logic        LW_Rn,
    inout  wire  [31:0] LAD_BUS,
    output logic        READYn,
    output logic [31:0] REG0_OUT,
    output logic        ERR_PULSE
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned NREGS  = 16;
    localparam logic [DATA_W-1:0] MISS_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_WAIT  = 2'd1,
        T_DRIVE = 2'd2,
        T_READY = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   idx;
    logic               hit;
    logic               is_write;
    logic               drive_en;
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  regs [NREGS];
    logic               accept_c;
    logic               hit_c;

    assign hit_c = ((LAD_BUS ^ BASE_ADDR) & ADDR_MASK) == '0;

    // The edge leaving T_READY is the first idle edge, so an address phase is taken there too.
    assign accept_c = !ADSn && LHOLDA && ((state == T_IDLE) || (state == T_READY));

    // Next-state: the wait phase lasts WAIT_STATES+1 cycles so data leads READYn by a full cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            T_IDLE:  state_next = T_IDLE;
            T_WAIT: begin
                if (cnt == '0) begin
                    state_next = T_DRIVE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            T_DRIVE: state_next = T_READY;
            T_READY: state_next = T_IDLE;
            default: state_next = T_IDLE;
        endcase
        if (accept_c) begin
            state_next = T_WAIT;
            cnt_next   = CNT_W'(WAIT_STATES);
        end
    end

    // Control state, address-phase latches and registered outputs.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= T_IDLE;
            cnt       <= '0;
            idx       <= '0;
            hit       <= 1'b0;
            is_write  <= 1'b0;
            rdata     <= '0;
            drive_en  <= 1'b0;
            READYn    <= 1'b1;
            ERR_PULSE <= 1'b0;
            LHOLDA    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept_c) begin
                idx      <= LAD_BUS[5:2];
                hit      <= hit_c;
                is_write <= LW_Rn;
            end
            if ((state == T_WAIT) && (state_next == T_DRIVE)) begin
                rdata <= hit ? regs[idx] : MISS_DATA;
            end
            drive_en  <= !is_write && ((state_next == T_DRIVE) || (state_next == T_READY));
            READYn    <= (state_next != T_READY);
            ERR_PULSE <= (state_next == T_READY) && !hit;
            // A busy local side only blocks new grants; release waits for an idle FSM.
            if (LHOLD && !LOCAL_BUSY) begin
                LHOLDA <= 1'b1;
            end else if (!LHOLD && (state == T_IDLE)) begin
                LHOLDA <= 1'b0;
            end
        end
    end

    // Register file: write data is taken on the edge that enters T_READY.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if ((state == T_DRIVE) && is_write && hit) begin
            regs[idx] <= LAD_BUS;
        end
    end

    assign LAD_BUS  = drive_en ? rdata : 32'bz;
    assign REG0_OUT = regs[0];

endmodule

// File: tb/tb_loc_bus_target.sv
// Bench for loc_bus_target: two targets (2 and 0 wait states) share the stimulus and are
// compared every cycle against a timeline model of the bus protocol.
module tb_loc_bus_target;

    localparam int N0 = 2;
    localparam int N1 = 0;
    localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;

    logic        CLOCK = 1'b0;
    logic        RESETn, LHOLD, LOCAL_BUSY, ADSn, LW_Rn;
    logic [31:0] tb_bus;
    logic        tb_drv;
    wire  [31:0] bus0, bus1;
    logic        lholda0, lholda1, readyn0, readyn1, err0, err1;
    logic [31:0] reg0_0, reg0_1;

    always #5 CLOCK = ~CLOCK;

    assign bus0 = tb_drv ? tb_bus : 32'bz;
    assign bus1 = tb_drv ? tb_bus : 32'bz;
    pullup (bus0);
    pullup (bus1);

    loc_bus_target #(.WAIT_STATES(N0)) u0 (
        .CLOCK(CLOCK), .RESETn(RESETn), .LHOLD(LHOLD), .LHOLDA(lholda0),
        .LOCAL_BUSY(LOCAL_BUSY), .ADSn(ADSn), .LW_Rn(LW_Rn), .LAD_BUS(bus0),
        .READYn(readyn0), .REG0_OUT(reg0_0), .ERR_PULSE(err0)
    );

    loc_bus_target #(.WAIT_STATES(N1)) u1 (
        .CLOCK(CLOCK), .RESETn(RESETn), .LHOLD(LHOLD), .LHOLDA(lholda1),
        .LOCAL_BUSY(LOCAL_BUSY), .ADSn(ADSn), .LW_Rn(LW_Rn), .LAD_BUS(bus1),
        .READYn(readyn1), .REG0_OUT(reg0_1), .ERR_PULSE(err1)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int e0;
    int lows;

    // Model: one transaction timeline per target plus an expected register file.
    bit          m_have [2];
    bit          m_wr   [2];
    bit          m_hit  [2];
    bit          m_gnt  [2];
    int          m_e0   [2];
    int          m_rdy  [2];
    int          m_idx  [2];
    logic [31:0] m_data [2];
    logic [31:0] m_regs [2][16];

    int          r_lat [2];
    logic [31:0] r_rd  [2];
    bit          r_er  [2];

    function automatic logic [31:0] bus_of(input int i);
        return (i == 0) ? bus0 : bus1;
    endfunction
    function automatic logic readyn_of(input int i);
        return (i == 0) ? readyn0 : readyn1;
    endfunction
    function automatic logic err_of(input int i);
        return (i == 0) ? err0 : err1;
    endfunction
    function automatic logic lholda_of(input int i);
        return (i == 0) ? lholda0 : lholda1;
    endfunction
    function automatic logic [31:0] reg0_of(input int i);
        return (i == 0) ? reg0_0 : reg0_1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_have[i] = 1'b0;
            m_wr[i]   = 1'b0;
            m_hit[i]  = 1'b0;
            m_gnt[i]  = 1'b0;
            m_e0[i]   = 0;
            m_rdy[i]  = 0;
            m_idx[i]  = 0;
            m_data[i] = '0;
            for (int r = 0; r < 16; r++) m_regs[i][r] = '0;
        end
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h (edge %0d)", name, inst, act, exp, edge_n);
        end
    endtask

    always @(posedge CLOCK or negedge RESETn) begin
        int          n;
        bit          busy;
        logic [31:0] cur;
        if (!RESETn) begin
            model_reset();
        end else begin
            edge_n++;
            for (int i = 0; i < 2; i++) begin
                n    = (i == 0) ? N0 : N1;
                busy = m_have[i] && (edge_n > m_e0[i]) && (edge_n <= m_rdy[i] + 1);
                cur  = bus_of(i);
                if (m_have[i] && m_wr[i] && m_hit[i] && (edge_n == m_rdy[i]))
                    m_regs[i][m_idx[i]] = cur;
                if (!ADSn && m_gnt[i] && (!m_have[i] || (edge_n > m_rdy[i]))) begin
                    m_have[i] = 1'b1;
                    m_e0[i]   = edge_n;
                    m_rdy[i]  = edge_n + n + 2;
                    m_wr[i]   = LW_Rn;
                    m_hit[i]  = (cur & 32'hFFFF_FFC0) == 32'h0;
                    m_idx[i]  = int'(cur[5:2]);
                    m_data[i] = m_hit[i] ? m_regs[i][m_idx[i]] : 32'hDEAD_BEEF;
                end
                if (!m_gnt[i] && LHOLD && !LOCAL_BUSY) m_gnt[i] = 1'b1;
                else if (m_gnt[i] && !LHOLD && !busy) m_gnt[i] = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLOCK) begin
        bit          in_rdy;
        bit          drv;
        logic [31:0] exp_bus;
        for (int i = 0; i < 2; i++) begin
            in_rdy  = m_have[i] && (edge_n == m_rdy[i]);
            drv     = m_have[i] && !m_wr[i] && ((edge_n == m_rdy[i] - 1) || (edge_n == m_rdy[i]));
            exp_bus = drv ? m_data[i] : (tb_drv ? tb_bus : ZBUS);
            check("cyc_readyn", i, 32'(readyn_of(i)), 32'(!in_rdy));
            check("cyc_err",    i, 32'(err_of(i)),    32'(in_rdy && !m_hit[i]));
            check("cyc_lholda", i, 32'(lholda_of(i)), 32'(m_gnt[i]));
            check("cyc_reg0",   i, reg0_of(i),        m_regs[i][0]);
            check("cyc_bus",    i, bus_of(i),         exp_bus);
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 2; i++) begin
            r_lat[i] = -1;
            r_rd[i]  = '0;
            r_er[i]  = 1'b0;
        end
        for (int k = 0; (k < 16) && ((r_lat[0] < 0) || (r_lat[1] < 0)); k++) begin
            @(negedge CLOCK);
            for (int i = 0; i < 2; i++) begin
                if ((r_lat[i] < 0) && (readyn_of(i) == 1'b0)) begin
                    r_lat[i] = edge_n - e0;
                    r_rd[i]  = bus_of(i);
                    r_er[i]  = err_of(i);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (r_lat[i] < 0) begin
                errors++;
                $display("FAIL ready_timeout inst%0d: got no READYn expected one within 16 cycles", i);
            end
        end
    endtask

    task automatic bus_cycle(input logic [31:0] addr, input bit wr, input logic [31:0] wdata);
        ADSn = 1'b0; LW_Rn = wr; tb_bus = addr; tb_drv = 1'b1;
        @(posedge CLOCK); #1;
        e0 = edge_n;
        ADSn = 1'b1; LW_Rn = 1'b0;
        if (wr) tb_bus = wdata;
        else    tb_drv = 1'b0;
        wait_ready();
        @(posedge CLOCK); #1;
        tb_drv = 1'b0;
    endtask

    logic [31:0] b2b_addr [4] = '{32'h00, 32'h3C, 32'h04, 32'h40};
    logic [31:0] b2b_exp  [4] = '{32'hCAFE_0001, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF};
    logic [31:0] tight_rd;

    initial begin
        model_reset();
        RESETn = 1'b0; LHOLD = 1'b0; LOCAL_BUSY = 1'b0; ADSn = 1'b1; LW_Rn = 1'b0;
        tb_bus = '0; tb_drv = 1'b0;
        repeat (3) @(posedge CLOCK); #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_readyn", i, 32'(readyn_of(i)), 32'd1);
            check("rst_lholda", i, 32'(lholda_of(i)), 32'd0);
            check("rst_reg0",   i, reg0_of(i),        32'd0);
            check("rst_bus",    i, bus_of(i),         ZBUS);
        end
        RESETn = 1'b1;

        // Grant withheld while busy; an ungranted address strobe is ignored.
        LHOLD = 1'b1; LOCAL_BUSY = 1'b1;
        repeat (3) @(posedge CLOCK); #1;
        for (int i = 0; i < 2; i++) check("busy_lholda", i, 32'(lholda_of(i)), 32'd0);
        ADSn = 1'b0; tb_bus = 32'h0; tb_drv = 1'b1;
        @(posedge CLOCK); #1;
        ADSn = 1'b1; tb_drv = 1'b0;
        lows = 0;
        repeat (6) begin
            @(negedge CLOCK);
            if (!readyn0 || !readyn1) lows++;
        end
        check("nogrant_ready", 0, 32'(lows), 32'd0);
        @(posedge CLOCK); #1;
        LOCAL_BUSY = 1'b0;
        @(posedge CLOCK); #1;
        for (int i = 0; i < 2; i++) check("grant_lat", i, 32'(lholda_of(i)), 32'd1);
        LOCAL_BUSY = 1'b1;
        repeat (2) @(posedge CLOCK); #1;
        for (int i = 0; i < 2; i++) check("busy_keeps_grant", i, 32'(lholda_of(i)), 32'd1);
        LOCAL_BUSY = 1'b0;

        // Write then read register 0.
        bus_cycle(32'h00, 1'b1, 32'hCAFE_0001);
        check("wr_lat", 0, 32'(r_lat[0]), 32'd4);
        check("wr_lat", 1, 32'(r_lat[1]), 32'd2);
        for (int i = 0; i < 2; i++) begin
            check("wr_reg0", i, reg0_of(i), 32'hCAFE_0001);
            check("wr_err",  i, 32'(r_er[i]), 32'd0);
        end
        bus_cycle(32'h00, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) check("rd_data", i, r_rd[i], 32'hCAFE_0001);
        check("rd_lat", 0, 32'(r_lat[0]), 32'd4);
        check("rd_release", 0, bus0, ZBUS);

        // Top register, zero-wait target latency.
        bus_cycle(32'h3C, 1'b1, 32'h1234_5678);
        check("zw_wr_lat", 1, 32'(r_lat[1]), 32'd2);
        bus_cycle(32'h3C, 1'b0, 32'h0);
        check("zw_rd_lat", 1, 32'(r_lat[1]), 32'd2);
        check("zw_rd_data", 1, r_rd[1], 32'h1234_5678);

        // Unmapped read and write.
        bus_cycle(32'h40, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check("miss_rd_data", i, r_rd[i], 32'hDEAD_BEEF);
            check("miss_rd_err",  i, 32'(r_er[i]), 32'd1);
        end
        bus_cycle(32'h80, 1'b1, 32'h5555_AAAA);
        for (int i = 0; i < 2; i++) begin
            check("miss_wr_err",  i, 32'(r_er[i]), 32'd1);
            check("miss_wr_reg0", i, reg0_of(i), 32'hCAFE_0001);
        end

        // Back-to-back reads at the tightest spacing that keeps the bus contention-free.
        for (int k = 0; k < 4; k++) begin
            bus_cycle(b2b_addr[k], 1'b0, 32'h0);
            check("b2b_data", 0, r_rd[0], b2b_exp[k]);
            check("b2b_lat",  0, 32'(r_lat[0]), 32'd4);
        end

        // Next address phase on the edge leaving the write's READYn cycle.
        ADSn = 1'b0; LW_Rn = 1'b1; tb_bus = 32'h08; tb_drv = 1'b1;
        @(posedge CLOCK); #1;
        e0 = edge_n;
        ADSn = 1'b1; LW_Rn = 1'b0; tb_bus = 32'h0BAD_F00D;
        repeat (4) @(posedge CLOCK); #1;
        ADSn = 1'b0; tb_bus = 32'h08;
        @(posedge CLOCK); #1;
        ADSn = 1'b1; tb_drv = 1'b0;
        lows = 0;
        tight_rd = '0;
        repeat (6) begin
            @(negedge CLOCK);
            if (!readyn0) begin
                lows++;
                tight_rd = bus0;
            end
        end
        check("tight_ready_count", 0, 32'(lows), 32'd1);
        check("tight_rd_data", 0, tight_rd, 32'h0BAD_F00D);
        @(posedge CLOCK); #1;

        // LHOLD dropped mid-cycle: cycle completes, grant releases once idle.
        ADSn = 1'b0; tb_bus = 32'h04; tb_drv = 1'b1;
        @(posedge CLOCK); #1;
        e0 = edge_n;
        ADSn = 1'b1; tb_drv = 1'b0; LHOLD = 1'b0;
        wait_ready();
        check("drop_lat", 0, 32'(r_lat[0]), 32'd4);
        check("drop_lat", 1, 32'(r_lat[1]), 32'd2);
        check("drop_hold", 0, 32'(lholda0), 32'd1);
        repeat (3) @(posedge CLOCK); #1;
        for (int i = 0; i < 2; i++) check("drop_lholda", i, 32'(lholda_of(i)), 32'd0);

        // Reset while the read data is on the bus.
        LHOLD = 1'b1;
        repeat (2) @(posedge CLOCK); #1;
        ADSn = 1'b0; tb_bus = 32'h00; tb_drv = 1'b1;
        @(posedge CLOCK); #1;
        ADSn = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge CLOCK); #1;
        check("pre_rst_bus", 0, bus0, 32'hCAFE_0001);
        RESETn = 1'b0;
        #1;
        check("midrst_readyn", 0, 32'(readyn0), 32'd1);
        check("midrst_bus",    0, bus0, ZBUS);
        check("midrst_err",    0, 32'(err0), 32'd0);
        for (int i = 0; i < 2; i++) check("midrst_reg0", i, reg0_of(i), 32'd0);
        @(posedge CLOCK); #1;
        RESETn = 1'b1;
        repeat (2) @(posedge CLOCK); #1;
        bus_cycle(32'h3C, 1'b1, 32'hA5A5_0F0F);
        check("post_rst_lat", 0, 32'(r_lat[0]), 32'd4);
        check("post_rst_lat", 1, 32'(r_lat[1]), 32'd2);
        bus_cycle(32'h3C, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) check("post_rst_data", i, r_rd[i], 32'hA5A5_0F0F);

        repeat (3) @(posedge CLOCK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected completion within 100000 time units");
        $fatal(1);
    end

endmodule
